fc_layer_stream: RTL and testbench
==================================

Name: fc_layer_stream

Overview:
- Parametrised fully-connected CNN/regression layer: NN neurons in parallel, each with its own weight memory, bias register and MAC accumulator.
- Consumes one input sample per handshake and emits all NN results together after NUM_WEIGHT samples.
- Loaded at runtime through the shared layer/neuron config bus.
- Adds over the previous layer generation: ready/valid backpressure on both sides, selectable activation, and saturating signed fixed-point output.

Parameters:
- NN, 4, neuron count
- NUM_WEIGHT, 8, inputs per frame (weights per neuron)
- DATA_WIDTH, 16, signed fixed-point width of data, weights and bias
- FRAC_WIDTH, 8, fractional bits (Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH)
- LAYER_NUM, 1, config address this layer answers to
- ACT_TYPE, 0, activation: 0 = identity (regression), 1 = ReLU

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_weight_valid  in  1  weight write strobe
- cfg_bias_valid  in  1  bias write strobe
- cfg_weight_value  in  DATA_WIDTH  weight data
- cfg_bias_value  in  DATA_WIDTH  bias data
- cfg_layer_num  in  8  target layer
- cfg_neuron_num  in  8  target neuron
- x_valid  in  1  input sample valid
- x_ready  out  1  input sample accepted when high with x_valid
- x_in  in  DATA_WIDTH  input sample
- o_valid  out  1  result frame valid
- o_ready  in  1  downstream accepts frame
- x_out  out  NN*DATA_WIDTH  results; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset: state ACC, sample count 0, accumulators 0, weights/bias 0, weight write pointers 0, x_ready 0 during reset, o_valid 0, x_out 0.
- Config hit: strobe high, cfg_layer_num==LAYER_NUM and cfg_neuron_num<NN.
  - Weight hit: write weight[ptr[n]] of neuron n, then ptr[n] increments, wrapping NUM_WEIGHT-1 -> 0.
  - Bias hit: overwrite bias[n].
  - Misses are ignored.
  - Config is accepted only in ACC with sample count 0; otherwise dropped.
  - Both strobes may hit in one cycle; both writes occur.
- x_ready = (state==ACC) && !cfg_weight_valid && !cfg_bias_valid. Config has priority over input.
- States:
  - ACC: each accepted sample i (count 0..NUM_WEIGHT-1) adds x_in*weight[i] (2*DATA_WIDTH signed) to the accumulator; count increments. Accepting the last sample -> BIAS.
  - BIAS: add sign-extended bias<<FRAC_WIDTH -> ACT.
  - ACT: arithmetic shift right FRAC_WIDTH (truncate), saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], apply ReLU if ACT_TYPE==1, register into x_out -> OUT.
  - OUT: o_valid=1, x_out held stable until o_ready. On handshake: accumulators and count clear -> ACC, x_ready high next cycle.
- Latency: o_valid rises 2 cycles after the cycle the last sample is accepted. Throughput: one frame per NUM_WEIGHT+3 cycles at full rate.
- Gaps in x_valid stall the accumulation only; there is no timeout.
- The accumulator has log2(NUM_WEIGHT) guard bits so no internal wrap occurs before saturation.
- Reset mid-frame discards the partial sum and loaded weights.

Optional Feature:
- Macro: FC_LAYER_OVF_FLAG_EN.
- When defined:
  - Extra output o_sat (NN bits). Bit k is registered with x_out and high when neuron k saturated in that frame.
  - Extra output sat_sticky (1 bit). High once any saturation has occurred; cleared only by rst.
- When undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package fc_layer_pkg holds:
  - ACT_NONE=0 and ACT_RELU=1 constants
  - state encoding ACC/BIAS/ACT/OUT
  - saturate-and-shift function
- Sub-module fc_neuron_mac (weight memory, write pointer, bias, accumulator, output stage) is instantiated NN times by generate.
- The top holds the FSM, counter and handshakes.

Test Plan:
- Load neuron0 weights 8x 0x0100, bias 0x0080, then stream x=0x0100..0x0800 -> x_out[15:0]=0x2480 (36.5), o_valid 2 cycles after last accept.
- Neuron1 weights 8x 0xFF00, bias 0, same inputs -> 0xDC00 with ACT_TYPE=0; 0x0000 with ACT_TYPE=1.
- Neuron2 weights 0x7FFF, inputs 0x7FFF -> 0x7FFF. Weights 0x8000, inputs 0x7FFF -> 0x8000. With FC_LAYER_OVF_FLAG_EN, o_sat[2]=1 and sat_sticky=1.
- Hold o_ready low 5 cycles in OUT -> x_out stable, o_valid=1, x_ready=0; raise o_ready -> x_ready=1 next cycle, second frame correct.
- Config with cfg_layer_num=2, or cfg_neuron_num=NN, or mid-frame -> no weight change (rerun first scenario, same result). Cfg strobe concurrent with x_valid -> x_ready=0 that cycle.
- Assert rst after 3 samples -> o_valid=0, x_out=0. The next full frame with zero weights yields 0x0000 plus bias.

Source files
------------

// File: rtl/fc_layer_pkg.sv
// Shared types and helpers for the streaming fully-connected layer.
package fc_layer_pkg;

   localparam int unsigned ACT_NONE = 0;
   localparam int unsigned ACT_RELU = 1;
   localparam int unsigned SAT_W    = 64;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      BIAS = 2'd1,
      ACT  = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Arithmetic shift right by fw, then clamp to the signed dw-bit range (result sign-extended).
   function automatic logic signed [SAT_W-1:0] shift_sat(
      input logic signed [SAT_W-1:0] acc,
      input int unsigned             dw,
      input int unsigned             fw
   );
      logic signed [SAT_W-1:0] shifted;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      shifted = acc >>> fw;
      max_v   = (SAT_W'(64'sd1) <<< (dw - 1)) - SAT_W'(64'sd1);
      min_v   = ~max_v;
      if (shifted > max_v) begin
         return max_v;
      end
      if (shifted < min_v) begin
         return min_v;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/fc_layer_stream_mac.sv
// One neuron: weight memory with wrapping write pointer, bias, MAC accumulator and output stage.
// With FC_LAYER_OVF_FLAG_EN defined the neuron also reports saturation through sat.
module fc_neuron_mac
   import fc_layer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_WIDTH = 8,
   parameter int unsigned NUM_WEIGHT = 8,
   parameter int unsigned IDX_W      = 3,
   parameter int unsigned ACT_TYPE   = ACT_NONE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  weight_we,
   input  logic                  bias_we,
   input  logic [DATA_WIDTH-1:0] weight_value,
   input  logic [DATA_WIDTH-1:0] bias_value,
   input  logic                  mac_en,
   input  logic [IDX_W-1:0]      sample_idx,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic                  bias_en,
   input  logic                  act_en,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] result
`ifdef FC_LAYER_OVF_FLAG_EN
   ,
   output logic                  sat
`endif
);

   // Guard bits cover NUM_WEIGHT products plus the shifted bias.
   localparam int unsigned ACC_W = 2 * DATA_WIDTH + IDX_W + 1;

   logic signed [DATA_WIDTH-1:0]   weight_mem [NUM_WEIGHT];
   logic        [IDX_W-1:0]        wr_ptr;
   logic signed [DATA_WIDTH-1:0]   bias;
   logic signed [ACC_W-1:0]        acc;
   logic signed [2*DATA_WIDTH-1:0] prod_c;
   logic signed [DATA_WIDTH-1:0]   clamp_c;
   logic signed [DATA_WIDTH-1:0]   act_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         bias   <= '0;
         for (int i = 0; i < NUM_WEIGHT; i++) begin
            weight_mem[i] <= '0;
         end
      end else begin
         if (weight_we) begin
            weight_mem[wr_ptr] <= weight_value;
            wr_ptr <= (wr_ptr == IDX_W'(NUM_WEIGHT - 1)) ? '0 : wr_ptr + IDX_W'(1);
         end
         if (bias_we) begin
            bias <= bias_value;
         end
      end
   end

   always_comb prod_c = $signed(x_in) * weight_mem[sample_idx];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '0;
      end else if (mac_en) begin
         acc <= acc + ACC_W'(prod_c);
      end else if (bias_en) begin
         acc <= acc + (ACC_W'(bias) <<< FRAC_WIDTH);
      end
   end

   always_comb begin
      clamp_c = DATA_WIDTH'(shift_sat(SAT_W'(acc), DATA_WIDTH, FRAC_WIDTH));
      act_c   = clamp_c;
      if (ACT_TYPE == ACT_RELU && clamp_c[DATA_WIDTH-1]) begin
         act_c = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
      end else if (act_en) begin
         result <= act_c;
      end
   end

`ifdef FC_LAYER_OVF_FLAG_EN
   // Saturated whenever the clamp changed the shifted sum.
   logic sat_c;
   always_comb sat_c = (acc >>> FRAC_WIDTH) != ACC_W'(clamp_c);

   always_ff @(posedge clk) begin
      if (rst) begin
         sat <= 1'b0;
      end else if (act_en) begin
         sat <= sat_c;
      end
   end
`endif

endmodule

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: control FSM, sample counter, handshakes and config decode.
// Optional FC_LAYER_OVF_FLAG_EN adds o_sat and sat_sticky saturation reporting.
module fc_layer_stream
   import fc_layer_pkg::*;
#(
   parameter int unsigned NN         = 4,
   parameter int unsigned NUM_WEIGHT = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_WIDTH = 8,
   parameter int unsigned LAYER_NUM  = 1,
   parameter int unsigned ACT_TYPE   = ACT_NONE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_weight_valid,
   input  logic                     cfg_bias_valid,
   input  logic [DATA_WIDTH-1:0]    cfg_weight_value,
   input  logic [DATA_WIDTH-1:0]    cfg_bias_value,
   input  logic [7:0]               cfg_layer_num,
   input  logic [7:0]               cfg_neuron_num,
   input  logic                     x_valid,
   output logic                     x_ready,
   input  logic [DATA_WIDTH-1:0]    x_in,
   output logic                     o_valid,
   input  logic                     o_ready,
   output logic [NN*DATA_WIDTH-1:0] x_out
`ifdef FC_LAYER_OVF_FLAG_EN
   ,
   output logic [NN-1:0]            o_sat,
   output logic                     sat_sticky
`endif
);

   localparam int unsigned CNT_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic             last_c;
   logic             mac_en_c;
   logic             bias_en_c;
   logic             act_en_c;
   logic             handshake_c;
   logic             cfg_open_c;
   logic             layer_hit_c;
   logic [NN-1:0]    weight_we_c;
   logic [NN-1:0]    bias_we_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   always_comb last_c = (count == CNT_W'(NUM_WEIGHT - 1));

   always_comb begin
      state_next = state;
      case (state)
         ACC:     if (mac_en_c && last_c) state_next = BIAS;
         BIAS:    state_next = ACT;
         ACT:     state_next = OUT;
         OUT:     if (o_ready) state_next = ACC;
         default: state_next = ACC;
      endcase
   end

   // Config strobes take priority over input samples.
   always_comb begin
      x_ready     = 1'b0;
      o_valid     = 1'b0;
      mac_en_c    = 1'b0;
      bias_en_c   = 1'b0;
      act_en_c    = 1'b0;
      handshake_c = 1'b0;
      case (state)
         ACC: begin
            x_ready  = !rst && !cfg_weight_valid && !cfg_bias_valid;
            mac_en_c = x_ready && x_valid;
         end
         BIAS:    bias_en_c = 1'b1;
         ACT:     act_en_c  = 1'b1;
         OUT: begin
            o_valid     = 1'b1;
            handshake_c = o_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || handshake_c) begin
         count <= '0;
      end else if (mac_en_c) begin
         count <= last_c ? '0 : count + CNT_W'(1);
      end
   end

   // Weights and biases may only change between frames.
   always_comb begin
      cfg_open_c  = (state == ACC) && (count == '0);
      layer_hit_c = (cfg_layer_num == 8'(LAYER_NUM));
      weight_we_c = '0;
      bias_we_c   = '0;
      for (int k = 0; k < NN; k++) begin
         weight_we_c[k] = cfg_open_c && layer_hit_c && cfg_weight_valid && (cfg_neuron_num == 8'(k));
         bias_we_c[k]   = cfg_open_c && layer_hit_c && cfg_bias_valid && (cfg_neuron_num == 8'(k));
      end
   end

   for (genvar k = 0; k < NN; k++) begin : g_neuron
      fc_neuron_mac #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_WIDTH (FRAC_WIDTH),
         .NUM_WEIGHT (NUM_WEIGHT),
         .IDX_W      (CNT_W),
         .ACT_TYPE   (ACT_TYPE)
      ) u_mac (
         .clk          (clk),
         .rst          (rst),
         .weight_we    (weight_we_c[k]),
         .bias_we      (bias_we_c[k]),
         .weight_value (cfg_weight_value),
         .bias_value   (cfg_bias_value),
         .mac_en       (mac_en_c),
         .sample_idx   (count),
         .x_in         (x_in),
         .bias_en      (bias_en_c),
         .act_en       (act_en_c),
         .clear        (handshake_c),
         .result       (x_out[k*DATA_WIDTH +: DATA_WIDTH])
`ifdef FC_LAYER_OVF_FLAG_EN
         ,
         .sat          (o_sat[k])
`endif
      );
   end

`ifdef FC_LAYER_OVF_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_sticky <= 1'b0;
      end else if (|o_sat) begin
         sat_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream: identity and ReLU instances share all inputs.
module tb_fc_layer_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_weight_valid;
   logic        cfg_bias_valid;
   logic [15:0] cfg_weight_value;
   logic [15:0] cfg_bias_value;
   logic [7:0]  cfg_layer_num;
   logic [7:0]  cfg_neuron_num;
   logic        x_valid;
   logic [15:0] x_in;
   logic        o_ready;
   logic        x_ready, o_valid;
   logic [63:0] x_out;
   logic        x_ready_r, o_valid_r;
   logic [63:0] x_out_r;
`ifdef FC_LAYER_OVF_FLAG_EN
   logic [3:0]  o_sat, o_sat_r;
   logic        sat_sticky, sat_sticky_r;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fc_layer_stream #(.NN(4), .NUM_WEIGHT(8), .DATA_WIDTH(16), .FRAC_WIDTH(8),
                     .LAYER_NUM(1), .ACT_TYPE(0)) dut (
      .clk(clk), .rst(rst),
      .cfg_weight_valid(cfg_weight_valid), .cfg_bias_valid(cfg_bias_valid),
      .cfg_weight_value(cfg_weight_value), .cfg_bias_value(cfg_bias_value),
      .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
      .x_valid(x_valid), .x_ready(x_ready), .x_in(x_in),
      .o_valid(o_valid), .o_ready(o_ready), .x_out(x_out)
`ifdef FC_LAYER_OVF_FLAG_EN
      , .o_sat(o_sat), .sat_sticky(sat_sticky)
`endif
   );

   fc_layer_stream #(.NN(4), .NUM_WEIGHT(8), .DATA_WIDTH(16), .FRAC_WIDTH(8),
                     .LAYER_NUM(1), .ACT_TYPE(1)) dut_relu (
      .clk(clk), .rst(rst),
      .cfg_weight_valid(cfg_weight_valid), .cfg_bias_valid(cfg_bias_valid),
      .cfg_weight_value(cfg_weight_value), .cfg_bias_value(cfg_bias_value),
      .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
      .x_valid(x_valid), .x_ready(x_ready_r), .x_in(x_in),
      .o_valid(o_valid_r), .o_ready(o_ready), .x_out(x_out_r)
`ifdef FC_LAYER_OVF_FLAG_EN
      , .o_sat(o_sat_r), .sat_sticky(sat_sticky_r)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic wv, input logic bv, input logic [7:0] layer,
                      input logic [7:0] neuron, input logic [15:0] w, input logic [15:0] b);
      @(negedge clk);
      cfg_weight_valid = wv;
      cfg_bias_valid   = bv;
      cfg_layer_num    = layer;
      cfg_neuron_num   = neuron;
      cfg_weight_value = w;
      cfg_bias_value   = b;
      @(negedge clk);
      cfg_weight_valid = 1'b0;
      cfg_bias_valid   = 1'b0;
   endtask

   task automatic load_neuron(input logic [7:0] n, input logic [15:0] w, input logic [15:0] b);
      for (int i = 0; i < 8; i++) cfg(1'b1, 1'b0, 8'd1, n, w, 16'h0000);
      cfg(1'b0, 1'b1, 8'd1, n, 16'h0000, b);
   endtask

   task automatic send(input logic [15:0] v);
      int n = 0;
      @(negedge clk);
      x_valid = 1'b1;
      x_in    = v;
      while (!x_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 64'(x_ready), 64'd1);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(o_valid), 64'd1);
   endtask

   task automatic expect_frame(input string tag, input logic [63:0] e, input logic [63:0] er);
      wait_valid({tag, "_valid"});
      chk({tag, "_id"}, x_out, e);
      chk({tag, "_relu"}, x_out_r, er);
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      o_ready = 1'b0;
   endtask

   task automatic send_ramp();
      for (int k = 1; k <= 8; k++) send(16'(k * 256));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cfg_weight_valid = 1'b0; cfg_bias_valid = 1'b0;
      cfg_weight_value = '0;   cfg_bias_value = '0;
      cfg_layer_num = '0;      cfg_neuron_num = '0;
      x_valid = 1'b0; x_in = '0; o_ready = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_x_ready", 64'(x_ready), 64'd0);
      chk("rst_o_valid", 64'(o_valid), 64'd0);
      chk("rst_x_out", x_out, 64'd0);
      chk("rst_x_out_relu", x_out_r, 64'd0);
`ifdef FC_LAYER_OVF_FLAG_EN
      chk("rst_sticky", 64'(sat_sticky), 64'd0);
`endif
      rst = 1'b0;
      #1;
      chk("idle_x_ready", 64'(x_ready), 64'd1);

      load_neuron(8'd0, 16'h0100, 16'h0080);
      load_neuron(8'd1, 16'hFF00, 16'h0000);
      load_neuron(8'd2, 16'h7FFF, 16'h0000);
      load_neuron(8'd3, 16'h8000, 16'h0000);

      // Frame A: ramp inputs 1.0 .. 8.0, with latency check
      send_ramp();
      @(negedge clk); chk("lat_bias", 64'(o_valid), 64'd0);
      @(negedge clk); chk("lat_act", 64'(o_valid), 64'd0);
      @(negedge clk); chk("lat_out", 64'(o_valid), 64'd1);
      expect_frame("frameA", 64'h8000_7FFF_DC00_2480, 64'h0000_7FFF_0000_2480);
`ifdef FC_LAYER_OVF_FLAG_EN
      chk("frameA_sat", 64'(o_sat), 64'h000C);
      chk("frameA_sat_relu", 64'(o_sat_r), 64'h000C);
      chk("frameA_sticky", 64'(sat_sticky), 64'd1);
`endif

      // Frame B: full-scale inputs, then downstream backpressure
      for (int k = 0; k < 8; k++) send(16'h7FFF);
      wait_valid("frameB_wait");
      for (int c = 0; c < 5; c++) begin
         chk("bp_o_valid", 64'(o_valid), 64'd1);
         chk("bp_x_ready", 64'(x_ready), 64'd0);
         chk("bp_x_out", x_out, 64'h8000_7FFF_8000_7FFF);
         @(negedge clk);
      end
      expect_frame("frameB", 64'h8000_7FFF_8000_7FFF, 64'h0000_7FFF_0000_7FFF);
      chk("post_hs_x_ready", 64'(x_ready), 64'd1);
      chk("post_hs_o_valid", 64'(o_valid), 64'd0);
`ifdef FC_LAYER_OVF_FLAG_EN
      chk("frameB_sat", 64'(o_sat), 64'h000F);
`endif

      // Config misses: wrong layer, out-of-range neuron, then mid-frame writes
      cfg(1'b1, 1'b1, 8'd2, 8'd0, 16'h1234, 16'h7777);
      cfg(1'b1, 1'b1, 8'd1, 8'd4, 16'h1234, 16'h7777);
      send(16'h0100);
      @(negedge clk);
      cfg_weight_valid = 1'b1; cfg_bias_valid = 1'b1;
      cfg_layer_num = 8'd1;    cfg_neuron_num = 8'd0;
      cfg_weight_value = 16'h5555; cfg_bias_value = 16'h5555;
      x_valid = 1'b1; x_in = 16'h0200;
      #1;
      chk("cfg_prio_x_ready", 64'(x_ready), 64'd0);
      @(negedge clk);
      cfg_weight_valid = 1'b0; cfg_bias_valid = 1'b0; x_valid = 1'b0;
      for (int k = 2; k <= 8; k++) send(16'(k * 256));
      expect_frame("rerunA", 64'h8000_7FFF_DC00_2480, 64'h0000_7FFF_0000_2480);

      // Reset after three samples discards the partial sum and all weights
      for (int k = 1; k <= 3; k++) send(16'(k * 256));
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_o_valid", 64'(o_valid), 64'd0);
      chk("mid_rst_x_out", x_out, 64'd0);
      chk("mid_rst_x_ready", 64'(x_ready), 64'd0);
`ifdef FC_LAYER_OVF_FLAG_EN
      chk("mid_rst_sticky", 64'(sat_sticky), 64'd0);
`endif
      rst = 1'b0;

      // Simultaneous weight+bias hit on neuron 1, bias-only on neuron 0
      cfg(1'b1, 1'b1, 8'd1, 8'd1, 16'h0100, 16'h0010);
      cfg(1'b0, 1'b1, 8'd1, 8'd0, 16'h0000, 16'h0123);
      send_ramp();
      expect_frame("post_rst", 64'h0000_0000_0110_0123, 64'h0000_0000_0110_0123);
`ifdef FC_LAYER_OVF_FLAG_EN
      chk("post_rst_sat", 64'(o_sat), 64'h0000);
      chk("post_rst_sticky", 64'(sat_sticky), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
